sap2_mem_arbiter: RTL and testbench

Shares the single-port SAP-2 RAM between two requesters: the CPU datapath (fetch and operand accesses issued by the controller) and an external program loader fed from the chip's spare IOs. Arbitration is 2-way round-robin. The loader can also take an exclusive lock that holds the CPU while a program image is written. The block sits between the controller/memory-address logic and the memory module inside the SAP-2 top level.

---
 rtl/sap2_mem_arb_pkg.sv | 22 ++
 rtl/sap2_rr_pick2.sv | 31 +++
 rtl/sap2_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_sap2_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap2_mem_arb_pkg.sv
// rtl/sap2_mem_arb_pkg.sv - shared types and default widths for the SAP-2 memory arbiter
//
// Purpose : arbiter FSM states, requester ids and default bus widths.
// Ports   : none (package).
package sap2_mem_arb_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } arb_state_t;

   // Encoding doubles as the bit index of each requester in req/grant vectors.
   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_LD  = 1'b1
   } req_id_t;

endpackage

// File: rtl/sap2_rr_pick2.sv
// rtl/sap2_rr_pick2.sv - combinational 2-way round-robin picker
//
// Purpose : chooses one of two requesters; on a tie the one that did not win
//           last is chosen. The CPU can be masked out entirely.
// Ports   : i_req[1:0]    requests, bit 0 = CPU, bit 1 = loader
//           i_last_winner requester id of the previous grant (0 = CPU, 1 = LD)
//           i_mask_cpu    1 = CPU request is ignored
//           o_grant[1:0]  one-hot grant (or zero when nothing is eligible)
module sap2_rr_pick2
   import sap2_mem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_winner,
   input  logic       i_mask_cpu,
   output logic [1:0] o_grant
);

   logic [1:0] w_elig;

   assign w_elig = {i_req[1], i_req[0] & ~i_mask_cpu};

   always_comb begin
      o_grant = 2'b00;
      if (&w_elig) begin
         o_grant = (i_last_winner == REQ_LD) ? 2'b01 : 2'b10;
      end else begin
         o_grant = w_elig;
      end
   end

endmodule

// File: rtl/sap2_mem_arbiter.sv
// rtl/sap2_mem_arbiter.sv - SAP-2 RAM arbiter between the CPU and the program loader
//
// Purpose : shares the single-port RAM between the CPU datapath and the
//           external loader. One access in flight, 3 cycles each
//           (IDLE -> ISSUE -> RESP). The loader may lock out the CPU.
// Ports   : i_clk, i_rst                         clock, sync active-high reset
//           i_cpu_req/we/addr/wdata              CPU request (held until gnt)
//           o_cpu_gnt/done/rdata, o_cpu_hold     CPU grant, completion, read data, stall
//           i_ld_req/we/addr/wdata, i_ld_lock    loader request and exclusive lock
//           o_ld_gnt/done/rdata                  loader grant, completion, read data
//           o_mem_en/we/addr/wdata, i_mem_rdata  registered RAM interface
module sap2_mem_arbiter
   import sap2_mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)
(
   input  logic              i_clk,
   input  logic              i_rst,

   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_done,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_hold,

   input  logic              i_ld_req,
   input  logic              i_ld_we,
   input  logic [ADDR_W-1:0] i_ld_addr,
   input  logic [DATA_W-1:0] i_ld_wdata,
   output logic              o_ld_gnt,
   output logic              o_ld_done,
   output logic [DATA_W-1:0] o_ld_rdata,
   input  logic              i_ld_lock,

   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   arb_state_t        r_state;
   req_id_t           r_last_winner;  // also identifies the in-flight requester
   logic              r_lock;
   logic              r_acc_we;       // in-flight access is a write
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_cpu_done;
   logic              r_ld_done;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_ld_rdata;

   logic [1:0]        w_grant;
   logic              w_arb;

   sap2_rr_pick2 u_pick (
      .i_req         ({i_ld_req, i_cpu_req}),
      .i_last_winner (r_last_winner),
      .i_mask_cpu    (r_lock),
      .o_grant       (w_grant)
   );

   // Grants only exist in IDLE. The mask uses the registered lock, so a lock
   // raised in the same IDLE cycle as a CPU request does not block that grant.
   assign w_arb     = (r_state == IDLE) && !i_rst;
   assign o_cpu_gnt = w_arb & w_grant[0];
   assign o_ld_gnt  = w_arb & w_grant[1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_last_winner <= REQ_LD;
         r_lock        <= 1'b0;
         r_acc_we      <= 1'b0;
         r_mem_en      <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_cpu_done    <= 1'b0;
         r_ld_done     <= 1'b0;
         r_cpu_rdata   <= '0;
         r_ld_rdata    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_lock <= i_ld_lock;
               if (|w_grant) begin
                  r_last_winner <= w_grant[1] ? REQ_LD : REQ_CPU;
                  r_mem_en      <= 1'b1;
                  r_mem_we      <= w_grant[1] ? i_ld_we    : i_cpu_we;
                  r_acc_we      <= w_grant[1] ? i_ld_we    : i_cpu_we;
                  r_mem_addr    <= w_grant[1] ? i_ld_addr  : i_cpu_addr;
                  r_mem_wdata   <= w_grant[1] ? i_ld_wdata : i_cpu_wdata;
                  r_state       <= ISSUE;
               end
            end
            ISSUE: begin
               r_mem_en   <= 1'b0;
               r_mem_we   <= 1'b0;
               r_cpu_done <= (r_last_winner == REQ_CPU);
               r_ld_done  <= (r_last_winner == REQ_LD);
               r_state    <= RESP;
            end
            RESP: begin
               r_cpu_done <= 1'b0;
               r_ld_done  <= 1'b0;
               // Keep the last read value so rdata stays stable after done.
               if (!r_acc_we) begin
                  if (r_last_winner == REQ_CPU) begin
                     r_cpu_rdata <= i_mem_rdata;
                  end else begin
                     r_ld_rdata  <= i_mem_rdata;
                  end
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Read data is passed straight through from the RAM in the done cycle.
   assign o_cpu_rdata = (r_cpu_done && !r_acc_we) ? i_mem_rdata : r_cpu_rdata;
   assign o_ld_rdata  = (r_ld_done  && !r_acc_we) ? i_mem_rdata : r_ld_rdata;

   assign o_cpu_done  = r_cpu_done;
   assign o_ld_done   = r_ld_done;
   assign o_cpu_hold  = r_lock;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_sap2_mem_arbiter.sv
// tb/tb_sap2_mem_arbiter.sv - directed scoreboard bench for sap2_mem_arbiter
module tb_sap2_mem_arbiter;
   import sap2_mem_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_req, cpu_we, cpu_gnt, cpu_done, cpu_hold;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       ld_req, ld_we, ld_gnt, ld_done, ld_lock;
   logic [7:0] ld_addr, ld_wdata, ld_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       is_ld;
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   logic [7:0] ram [0:255];

   always #5 clk = ~clk;

   sap2_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cpu_req   (cpu_req),
      .i_cpu_we    (cpu_we),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_wdata (cpu_wdata),
      .o_cpu_gnt   (cpu_gnt),
      .o_cpu_done  (cpu_done),
      .o_cpu_rdata (cpu_rdata),
      .o_cpu_hold  (cpu_hold),
      .i_ld_req    (ld_req),
      .i_ld_we     (ld_we),
      .i_ld_addr   (ld_addr),
      .i_ld_wdata  (ld_wdata),
      .o_ld_gnt    (ld_gnt),
      .o_ld_done   (ld_done),
      .o_ld_rdata  (ld_rdata),
      .i_ld_lock   (ld_lock),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   // Single-port RAM model, read data one cycle after mem_en.
   always @(posedge clk) begin
      if (rst) begin
         ram[8'h0F] <= 8'hA5;
         ram[8'h10] <= 8'h5A;
         ram[8'h11] <= 8'hC3;
      end
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic is_ld, input logic we, input logic [7:0] addr,
                           input logic [7:0] data);
      exp_t e;
      e.is_ld = is_ld;
      e.we    = we;
      e.addr  = addr;
      e.data  = data;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: RAM strobes and done pulses against queued expectations.
   always @(negedge clk) begin
      exp_t e;
      chk("gnt_both", 32'(cpu_gnt & ld_gnt), 32'd0);
      if (mem_en) begin
         if (sb.size() == 0) begin
            chk("mem_en_unexpected", 32'(mem_en), 32'd0);
         end else begin
            chk("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
            chk("mem_we", 32'(mem_we), 32'(sb[0].we));
            if (sb[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(sb[0].data));
         end
      end
      if (cpu_done | ld_done) begin
         if (sb.size() == 0) begin
            chk("done_unexpected", 32'({ld_done, cpu_done}), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("done_who", 32'({ld_done, cpu_done}), e.is_ld ? 32'd2 : 32'd1);
            if (!e.we) chk("rdata", 32'(e.is_ld ? ld_rdata : cpu_rdata), 32'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_lock = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
      chk("rst_cpu_done", 32'(cpu_done), 32'd0);
      chk("rst_ld_done", 32'(ld_done), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_ld_rdata", 32'(ld_rdata), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

      // 1: CPU read without contention
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h0F;
      @(negedge clk);
      chk("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
      chk("t1_ld_gnt", 32'(ld_gnt), 32'd0);
      push_exp(1'b0, 1'b0, 8'h0F, 8'hA5);
      @(posedge clk); #1;
      cpu_req = 0;
      @(negedge clk);
      chk("t1_mem_en", 32'(mem_en), 32'd1);
      chk("t1_mem_addr", 32'(mem_addr), 32'h0F);
      chk("t1_cpu_gnt_issue", 32'(cpu_gnt), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_done", 32'(cpu_done), 32'd1);
      chk("t1_rdata", 32'(cpu_rdata), 32'hA5);
      chk("t1_mem_en_resp", 32'(mem_en), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_state_idle", 32'(dut.r_state), 32'(IDLE));
      chk("t1_done_clr", 32'(cpu_done), 32'd0);
      chk("t1_rdata_held", 32'(cpu_rdata), 32'hA5);

      // 2: tie-break and alternation, fresh from reset
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      ld_req = 1;  ld_we = 0;  ld_addr = 8'h11;
      for (int k = 0; k < 12; k++) begin
         logic exp_c, exp_l;
         @(negedge clk);
         exp_c = (k % 3 == 0) && ((k / 3) % 2 == 0);
         exp_l = (k % 3 == 0) && ((k / 3) % 2 == 1);
         chk("t2_cpu_gnt", 32'(cpu_gnt), 32'(exp_c));
         chk("t2_ld_gnt", 32'(ld_gnt), 32'(exp_l));
         if (exp_c) push_exp(1'b0, 1'b0, 8'h10, 8'h5A);
         if (exp_l) push_exp(1'b1, 1'b0, 8'h11, 8'hC3);
         @(posedge clk); #1;
         if (k == 10) begin
            cpu_req = 0;
            ld_req = 0;
         end
      end

      // 3: loader write under lock, CPU requesting throughout
      ld_lock = 1;
      @(negedge clk);
      chk("t3_hold_pre", 32'(cpu_hold), 32'd0);
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
      ld_req = 1;  ld_we = 1;  ld_addr = 8'h20; ld_wdata = 8'h3C;
      @(negedge clk);
      chk("t3_hold", 32'(cpu_hold), 32'd1);
      chk("t3_ld_gnt", 32'(ld_gnt), 32'd1);
      chk("t3_cpu_gnt", 32'(cpu_gnt), 32'd0);
      push_exp(1'b1, 1'b1, 8'h20, 8'h3C);
      @(posedge clk); #1;
      ld_req = 0; ld_we = 0;
      @(negedge clk);
      chk("t3_mem_we", 32'(mem_we), 32'd1);
      chk("t3_mem_addr", 32'(mem_addr), 32'h20);
      chk("t3_mem_wdata", 32'(mem_wdata), 32'h3C);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_ld_done", 32'(ld_done), 32'd1);
      chk("t3_cpu_gnt_resp", 32'(cpu_gnt), 32'd0);
      @(posedge clk); #1;
      ld_lock = 0;
      @(negedge clk);
      chk("t3_cpu_gnt_locked", 32'(cpu_gnt), 32'd0);
      chk("t3_hold_locked", 32'(cpu_hold), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_hold_released", 32'(cpu_hold), 32'd0);
      chk("t3_cpu_gnt_after", 32'(cpu_gnt), 32'd1);
      push_exp(1'b0, 1'b0, 8'h20, 8'h3C);
      @(posedge clk); #1;
      cpu_req = 0;
      repeat (2) @(posedge clk);
      #1;

      // 4: lock raised during the ISSUE of a CPU read
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h0F;
      @(negedge clk);
      chk("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
      push_exp(1'b0, 1'b0, 8'h0F, 8'hA5);
      @(posedge clk); #1;
      cpu_req = 0; ld_lock = 1;
      @(negedge clk);
      chk("t4_hold_issue", 32'(cpu_hold), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_cpu_done", 32'(cpu_done), 32'd1);
      chk("t4_hold_resp", 32'(cpu_hold), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_hold_idle", 32'(cpu_hold), 32'd0);
      @(posedge clk); #1;
      cpu_req = 1;
      @(negedge clk);
      chk("t4_hold_set", 32'(cpu_hold), 32'd1);
      chk("t4_cpu_gnt_held", 32'(cpu_gnt), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_cpu_gnt_held2", 32'(cpu_gnt), 32'd0);
      chk("t4_state_idle", 32'(dut.r_state), 32'(IDLE));
      @(posedge clk); #1;
      cpu_req = 0; ld_lock = 0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_hold_clear", 32'(cpu_hold), 32'd0);
      @(posedge clk); #1;

      // 5: reset during RESP of a loader read
      ld_req = 1; ld_we = 0; ld_addr = 8'h11;
      @(negedge clk);
      chk("t5_ld_gnt", 32'(ld_gnt), 32'd1);
      push_exp(1'b1, 1'b0, 8'h11, 8'hC3);
      @(posedge clk); #1;
      ld_req = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_ld_done_resp", 32'(ld_done), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_ld_done", 32'(ld_done), 32'd0);
      chk("t5_cpu_done", 32'(cpu_done), 32'd0);
      chk("t5_mem_en", 32'(mem_en), 32'd0);
      chk("t5_mem_we", 32'(mem_we), 32'd0);
      chk("t5_hold", 32'(cpu_hold), 32'd0);
      chk("t5_ld_rdata", 32'(ld_rdata), 32'd0);
      chk("t5_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("t5_mem_addr", 32'(mem_addr), 32'd0);
      chk("t5_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("t5_state_idle", 32'(dut.r_state), 32'(IDLE));
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      ld_req = 1;  ld_we = 0;  ld_addr = 8'h11;
      @(negedge clk);
      chk("t5_tie_cpu", 32'(cpu_gnt), 32'd1);
      chk("t5_tie_ld", 32'(ld_gnt), 32'd0);
      push_exp(1'b0, 1'b0, 8'h10, 8'h5A);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("t5_next_ld", 32'(ld_gnt), 32'd1);
      push_exp(1'b1, 1'b0, 8'h11, 8'hC3);
      @(posedge clk); #1;
      cpu_req = 0; ld_req = 0;

      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
